// File: rtl/ddr3_phy_init_seq_pkg.sv
// Shared DDR3 PHY definitions: init FSM states,
// default bring-up timing and the PHY clock rate.
package ddr3_phy_init_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_SERDES_RST = 3'd1,
    ST_CK_EN      = 3'd2,
    ST_DRAM_RST   = 3'd3,
    ST_CKE_WAIT   = 3'd4,
    ST_READY      = 3'd5
  } init_state_t;

  localparam int unsigned DDR3_CLK_MHZ = 200;

  localparam int unsigned LOCK_STABLE_DEF = 64;
  localparam int unsigned SERDES_RST_DEF  = 16;
  localparam int unsigned CK_EN_DEF       = 16;
  localparam int unsigned DRAM_RST_DEF    = 40000;
  localparam int unsigned CKE_DEF         = 100000;

  function automatic int unsigned max2(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr3_phy_init_seq_if.sv
// Status bundle from the PHY init sequencer
// to the SERDES, DRAM pins and controller.
interface ddr3_phy_init_seq_if;
  import ddr3_phy_init_seq_pkg::*;

  logic       serdes_rst;
  logic       ck_en;
  logic       ddr_reset_n;
  logic       ddr_cke;
  logic       phy_ready;
  logic       lock_lost;
  logic [2:0] state;

  modport master (
    output serdes_rst,
    output ck_en,
    output ddr_reset_n,
    output ddr_cke,
    output phy_ready,
    output lock_lost,
    output state
  );

  modport slave (
    input serdes_rst,
    input ck_en,
    input ddr_reset_n,
    input ddr_cke,
    input phy_ready,
    input lock_lost,
    input state
  );

endinterface

// File: rtl/ddr3_phy_init_seq_sync2.sv
// Two-flop synchronizer for asynchronous
// single-bit status into the local clock.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) ff <= '0;
    else       ff <= {ff[0], d};
  end

  assign q = ff[1];

endmodule

// File: rtl/ddr3_phy_init_seq.sv
// DDR3 PHY bring-up: PLL lock qualification,
// SERDES reset, CK enable, JEDEC RESET#/CKE.
module ddr3_phy_init_seq
  import ddr3_phy_init_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE       = LOCK_STABLE_DEF,
  parameter int unsigned SERDES_RST_CYCLES = SERDES_RST_DEF,
  parameter int unsigned CK_EN_CYCLES      = CK_EN_DEF,
  parameter int unsigned DRAM_RST_CYCLES   = DRAM_RST_DEF,
  parameter int unsigned CKE_CYCLES        = CKE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_locked,
  ddr3_phy_init_seq_if.master phy
);

  localparam int unsigned MAXP =
    max2(max2(max2(LOCK_STABLE, SERDES_RST_CYCLES),
              max2(CK_EN_CYCLES, DRAM_RST_CYCLES)),
         CKE_CYCLES);
  localparam int DW = $clog2(MAXP) + 1;
  localparam int RW = $clog2(LOCK_STABLE) + 1;

  logic          lock_s;
  init_state_t   st, st_n;
  logic [RW-1:0] run_q, run_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          lost_q, lost_d;

  sync2 u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (lock_s)
  );

  function automatic init_state_t next_of(
    input init_state_t s
  );
    case (s)
      ST_SERDES_RST: return ST_CK_EN;
      ST_CK_EN:      return ST_DRAM_RST;
      ST_DRAM_RST:   return ST_CKE_WAIT;
      default:       return ST_READY;
    endcase
  endfunction

  // Dwell counter is loaded with N-1 so it reads 0 on the Nth cycle.
  function automatic logic [DW-1:0] load_for(
    input init_state_t s
  );
    case (s)
      ST_SERDES_RST: return DW'(SERDES_RST_CYCLES - 1);
      ST_CK_EN:      return DW'(CK_EN_CYCLES - 1);
      ST_DRAM_RST:   return DW'(DRAM_RST_CYCLES - 1);
      ST_CKE_WAIT:   return DW'(CKE_CYCLES - 1);
      default:       return '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= ST_WAIT_LOCK;
      run_q   <= '0;
      dwell_q <= '0;
      lost_q  <= 1'b0;
    end else begin
      st      <= st_n;
      run_q   <= run_d;
      dwell_q <= dwell_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    st_n    = st;
    run_d   = run_q;
    dwell_d = dwell_q;
    lost_d  = lost_q;
    if (st == ST_WAIT_LOCK) begin
      if (!lock_s) begin
        run_d = '0;
      end else if (run_q == RW'(LOCK_STABLE)) begin
        st_n    = ST_SERDES_RST;
        run_d   = '0;
        dwell_d = load_for(ST_SERDES_RST);
      end else begin
        run_d = run_q + 1'b1;
      end
    end else if (!lock_s) begin
      // Lock loss wins over a dwell expiring on the same edge.
      st_n    = ST_WAIT_LOCK;
      lost_d  = 1'b1;
      dwell_d = '0;
    end else if (st != ST_READY) begin
      if (dwell_q == '0) begin
        st_n    = next_of(st);
        dwell_d = load_for(next_of(st));
      end else begin
        dwell_d = dwell_q - 1'b1;
      end
    end
  end

  assign phy.serdes_rst  = (st == ST_WAIT_LOCK) ||
                           (st == ST_SERDES_RST);
  assign phy.ck_en       = (st == ST_CK_EN)    ||
                           (st == ST_DRAM_RST) ||
                           (st == ST_CKE_WAIT) ||
                           (st == ST_READY);
  assign phy.ddr_reset_n = (st == ST_CKE_WAIT) ||
                           (st == ST_READY);
  assign phy.ddr_cke     = (st == ST_READY);
  assign phy.phy_ready   = (st == ST_READY);
  assign phy.lock_lost   = lost_q;
  assign phy.state       = st;

endmodule
